// File: rtl/bootloader_status_ctrl.sv
// Bootloader supervisor: us/ms tick generation, host-presence FSM, auto-boot decision and LED pattern.
// Optional macro BOOTLOADER_HOST_STICKY_EN: once a host is seen, only boot_req or reset leave HOST_ACTIVE.
module bootloader_status_ctrl #(
  parameter int CLK_HZ       = 48000000,
  parameter int PWM_BITS     = 8,
  parameter int STEP_US      = 1000,
  parameter int TIMEOUT_MS   = 1000,
  parameter int HOST_LOSS_MS = 50,
  parameter int BLINK_MS     = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sof_valid,
  input  logic       boot_req,
  output logic       boot,
  output logic       led,
  output logic [1:0] state,
  output logic       host_present
);

  localparam int US_DIV  = CLK_HZ / 1000000;
  localparam int PRE_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MAX_T   = (TIMEOUT_MS > HOST_LOSS_MS) ? TIMEOUT_MS : HOST_LOSS_MS;
  localparam int TMR_W   = $clog2(MAX_T + 2);
  localparam int STEP_W  = (STEP_US > 0) ? $clog2(STEP_US + 1) : 1;
  localparam int BLINK_W = (BLINK_MS > 0) ? $clog2(BLINK_MS + 1) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_HOST   = 2'd0,
    HOST_ACTIVE = 2'd1,
    BOOT        = 2'd2
  } state_t;

  state_t                cur_state, next_state;
  logic [PRE_W-1:0]      pre_cnt;
  logic [9:0]            ms_cnt;
  logic                  us_tick, ms_tick;
  logic [TMR_W-1:0]      tmr;
  logic                  host_loss;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [STEP_W-1:0]     step_cnt;
  logic [PWM_BITS-1:0]   bright;
  logic                  dir_down;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   level;

  assign us_tick      = (pre_cnt == PRE_W'(US_DIV - 1));
  assign ms_tick      = us_tick && (ms_cnt == 10'd999);
  assign state        = cur_state;
  assign host_present = (cur_state == HOST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
      if (us_tick)
        ms_cnt <= (ms_cnt == 10'd999) ? 10'd0 : ms_cnt + 10'd1;
    end
  end

  // Silence timer: a SOF or any state change restarts the count; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      tmr <= '0;
    else if (sof_valid || (next_state != cur_state))
      tmr <= '0;
    else if (ms_tick && (tmr != '1))
      tmr <= tmr + 1'b1;
  end

`ifdef BOOTLOADER_HOST_STICKY_EN
  assign host_loss = 1'b0;
`else
  assign host_loss = !sof_valid && (tmr == TMR_W'(HOST_LOSS_MS));
`endif

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      WAIT_HOST: begin
        if (boot_req)
          next_state = BOOT;
        else if (sof_valid)
          next_state = HOST_ACTIVE;
        else if (tmr == TMR_W'(TIMEOUT_MS))
          next_state = BOOT;
      end
      HOST_ACTIVE: begin
        if (boot_req || host_loss)
          next_state = BOOT;
      end
      BOOT:    next_state = BOOT;
      default: next_state = WAIT_HOST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= WAIT_HOST;
      boot      <= 1'b0;
    end else begin
      cur_state <= next_state;
      boot      <= (cur_state == BOOT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Breathing ramp: at either bound the interval is spent turning around rather than stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      bright   <= '0;
      dir_down <= 1'b0;
    end else if ((next_state == HOST_ACTIVE) && (cur_state != HOST_ACTIVE)) begin
      step_cnt <= '0;
      bright   <= '0;
      dir_down <= 1'b0;
    end else if ((cur_state == HOST_ACTIVE) && us_tick) begin
      if (step_cnt == STEP_W'(STEP_US - 1)) begin
        step_cnt <= '0;
        if (!dir_down) begin
          if (bright == LVL_MAX)
            dir_down <= 1'b1;
          else
            bright <= bright + 1'b1;
        end else begin
          if (bright == '0)
            dir_down <= 1'b0;
          else
            bright <= bright - 1'b1;
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    level = '0;
    case (cur_state)
      WAIT_HOST:   level = blink_phase ? LVL_MAX : '0;
      HOST_ACTIVE: level = bright;
      default:     level = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      led     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= (level > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_bootloader_status_ctrl.sv
// Self-checking bench for bootloader_status_ctrl: vector table for short sequences, hand sequences for timeouts and LED patterns.
module tb_bootloader_status_ctrl;

  localparam int CLK_HZ       = 4000000;
  localparam int PWM_BITS     = 3;
  localparam int STEP_US      = 1;
  localparam int TIMEOUT_MS   = 3;
  localparam int HOST_LOSS_MS = 2;
  localparam int BLINK_MS     = 1;
  localparam int MS_CYC       = 4000;

  logic       clk;
  logic       reset;
  logic       sof_valid;
  logic       boot_req;
  logic       boot;
  logic       led;
  logic [1:0] state;
  logic       host_present;

  int checks_total;
  int checks_passed;
  int now;

  typedef struct {
    logic       rst;
    logic       sof;
    logic       req;
    logic [1:0] st;
    logic       bt;
    logic       hp;
    logic       ld;
  } vec_t;

  vec_t vecs [16];

  bootloader_status_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .PWM_BITS    (PWM_BITS),
    .STEP_US     (STEP_US),
    .TIMEOUT_MS  (TIMEOUT_MS),
    .HOST_LOSS_MS(HOST_LOSS_MS),
    .BLINK_MS    (BLINK_MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sof_valid   (sof_valid),
    .boot_req    (boot_req),
    .boot        (boot),
    .led         (led),
    .state       (state),
    .host_present(host_present)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    sof_valid = 1'b0;
    boot_req  = 1'b0;
    tick(5);
    reset = 1'b0;
    now   = 0;
  endtask

  task automatic pulse_sof();
    sof_valid = 1'b1;
    tick(1);
    sof_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reset     = v.rst;
    sof_valid = v.sof;
    boot_req  = v.req;
    tick(1);
    checkOutput($sformatf("vec%0d_state", idx), int'(state), int'(v.st));
    checkOutput($sformatf("vec%0d_boot", idx), int'(boot), int'(v.bt));
    checkOutput($sformatf("vec%0d_host", idx), int'(host_present), int'(v.hp));
    checkOutput($sformatf("vec%0d_led", idx), int'(led), int'(v.ld));
  endtask

  initial begin
    int seq [18];
    int st_edge, bt_edge, b0, b1, b2, bad, cnt, exp_cnt, top_cnt, deadline, led_on;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1};

    checks_total  = 0;
    checks_passed = 0;
    now           = 0;
    reset         = 1'b1;
    sof_valid     = 1'b0;
    boot_req      = 1'b0;

    // Reset values
    reset_dut();
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_boot", int'(boot), 0);
    checkOutput("reset_led", int'(led), 0);
    checkOutput("reset_host", int'(host_present), 0);

    // Short sequences: boot_req priority, BOOT is terminal, reset out of BOOT
    for (int i = 0; i < 16; i++)
      applyStimulus(vecs[i], i);
    reset     = 1'b0;
    sof_valid = 1'b0;
    boot_req  = 1'b0;

    // No host: auto-boot after TIMEOUT_MS, blink pattern while waiting
    reset_dut();
    st_edge = -1;
    bt_edge = -1;
    b0 = 0;
    b1 = 0;
    b2 = 0;
    while (bt_edge < 0 && now < 13000) begin
      tick(1);
      if (now <= MS_CYC)
        b0 += int'(led);
      else if (now <= 2 * MS_CYC)
        b1 += int'(led);
      else if (now <= 3 * MS_CYC)
        b2 += int'(led);
      if (state == 2'd2 && st_edge < 0)
        st_edge = now;
      if (boot && bt_edge < 0)
        bt_edge = now;
    end
    checkOutput("s1_boot_seen", int'(bt_edge >= 0), 1);
    checkOutput("s1_state_edge", st_edge, TIMEOUT_MS * MS_CYC + 1);
    checkOutput("s1_boot_edge", bt_edge, TIMEOUT_MS * MS_CYC + 2);
    checkOutput("s1_blink_ms0_on", b0, 0);
    checkOutput("s1_blink_ms1_on", b1, MS_CYC * 7 / 8);
    checkOutput("s1_blink_ms2_on", b2, 0);
    checkOutput("s1_led_after_boot", int'(led), 0);
    bad    = 0;
    led_on = 0;
    for (int i = 0; i < 20000; i++) begin
      tick(1);
      if (!boot || state != 2'd2)
        bad++;
      led_on += int'(led);
    end
    checkOutput("s1_boot_hold_bad", bad, 0);
    checkOutput("s1_led_hold_on", led_on, 0);

    // Breathing ramp: SOF at edge 96 keeps pwm windows aligned to 4-value halves
    reset_dut();
    tick(95);
    pulse_sof();
    checkOutput("s5_state", int'(state), 1);
    checkOutput("s5_host", int'(host_present), 1);
    top_cnt = 0;
    for (int j = 0; j < 18; j++) begin
      cnt     = 0;
      exp_cnt = 0;
      for (int c = 0; c < 4; c++) begin
        tick(1);
        cnt += int'(led);
        if (seq[j] > (j % 2) * 4 + c)
          exp_cnt++;
      end
      if (j == 7 || j == 8)
        top_cnt += cnt;
      checkOutput($sformatf("s5_level_window%0d", j), cnt, exp_cnt);
    end
    checkOutput("s5_top_8cycle_on", top_cnt, 7);

    // Host seen, regular SOFs hold HOST_ACTIVE
    reset_dut();
    tick(99);
    pulse_sof();
    checkOutput("s2_state", int'(state), 1);
    checkOutput("s2_host", int'(host_present), 1);
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      while (now < 100 + MS_CYC * i - 1) begin
        tick(1);
        if (state != 2'd1 || boot)
          bad++;
      end
      pulse_sof();
    end
    checkOutput("s2_host_held_bad", bad, 0);

    // SOF exactly on the host-loss deadline keeps the host
    deadline = (now / MS_CYC + HOST_LOSS_MS) * MS_CYC + 1;
    while (now < deadline - 1)
      tick(1);
    pulse_sof();
    checkOutput("s3_sof_at_deadline", int'(state), 1);

    // SOFs stop
`ifdef BOOTLOADER_HOST_STICKY_EN
    bad = 0;
    for (int i = 0; i < 3 * MS_CYC; i++) begin
      tick(1);
      if (state != 2'd1 || boot)
        bad++;
    end
    checkOutput("s3_sticky_hold_bad", bad, 0);
`else
    deadline = (now / MS_CYC + HOST_LOSS_MS) * MS_CYC + 1;
    st_edge  = -1;
    while (st_edge < 0 && now < deadline + 2000) begin
      tick(1);
      if (state == 2'd2)
        st_edge = now;
    end
    checkOutput("s3_loss_edge", st_edge, deadline);
    tick(1);
    checkOutput("s3_loss_boot", int'(boot), 1);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
